ps2_keyboard_interface: RTL and testbench
=========================================

# ps2_keyboard_interface

Memory-mapped PS/2 keyboard receiver that feeds scan codes from the board's PS/2 port into the RISC-V core's data bus. It deserialises PS/2 device-to-host frames, checks them, and buffers the bytes in a FIFO. It exposes a status register and a data register on the same bus signals the core drives toward the video interface. It is instantiated in the FPGA top level under USE_KEYBOARD and is clocked by the core clock.

## Interface
- BASE_ADDRESS, 32'hFF20_0100, word-aligned base; status at +0, data at +4.
- FIFO_DEPTH, 16, receive FIFO entries; power of two, 2..16.
- FILTER_CYCLES, 8, consecutive equal samples required before a filtered PS/2 line changes.
- TIMEOUT_CYCLES, 50000, idle clocks mid-frame before the frame is aborted.
- clock  input  1  core clock; single clock domain for the whole block.
- reset  input  1  synchronous, active-high.
- ps2_clock  input  1  raw PS/2 clock line (asynchronous).
- ps2_data  input  1  raw PS/2 data line (asynchronous).
- bus_address  input  32  data bus address.
- bus_write_data  input  32  data bus write data.
- bus_format  input  3  access format; ignored, all accesses are treated as word.
- bus_read_enable  input  1  read strobe.
- bus_write_enable  input  1  write strobe.
- bus_data_fetched  output  32  read data; 0 when the block is not selected.

## Operation
- Decided: one clock (clock); reset is synchronous and active-high (reset).
- Input path: each line passes through a 2-FF synchronizer, then a filter. The filtered value changes only after FILTER_CYCLES consecutive identical synchronized samples. A falling edge of the filtered ps2_clock produces a one-cycle sample strobe, and filtered ps2_data is sampled on that strobe.
- Receiver FSM:
  - IDLE: a strobe with data=0 goes to DATA with bit count 0. A strobe with data=1 is ignored.
  - DATA: shifts the sample in LSB first. After the 8th bit, goes to PARITY.
  - PARITY: stores the parity bit, goes to STOP.
  - STOP: if stop=1 and data plus parity has odd ones, the byte is pushed. Otherwise frame_error is set. Always returns to IDLE.
  - Timeout: in any state other than IDLE, a counter clears on every strobe. When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE, sets frame_error, and discards the partial byte.
- FIFO:
  - Push when full: the byte is dropped, overflow is set, and contents are unchanged.
  - Pop happens on a rising edge where bus_read_enable=1, the data register is selected, and the FIFO is not empty. Popping an empty FIFO has no effect.
  - Simultaneous push and pop: both occur and the count is unchanged. A push into a full FIFO with a simultaneous pop succeeds, with no overflow.
- Address decode: selected when bus_address[31:3]==BASE_ADDRESS[31:3]. bus_address[2] picks the register. bits[1:0] are ignored.
- Status register (read): bit0 not_empty, bit1 full, bit2 overflow (sticky), bit3 frame_error (sticky), bits[12:8] count. All other bits are 0.
- Status register (write): bit2=1 clears overflow and bit3=1 clears frame_error. A 0 leaves the flag unchanged. A set event and a clear in the same cycle leaves the flag set.
- Data register (read): bits[7:0] FIFO head, bit8 = not_empty, other bits 0. Returns 0 when the FIFO is empty. Writes are ignored.
- bus_data_fetched is combinational from address, FIFO head and flags. It is 0 whenever the block is unselected or bus_read_enable=0.

## Timing
- Reset: FSM goes to IDLE, FIFO empty, count 0, flags 0, filters and synchronizers set to 1 (idle line), timeout counter 0. bus_data_fetched is 0.
- Reset mid-frame aborts the frame without setting any flag.
- Latency from a raw ps2_clock falling edge to the strobe: 2 synchronizer cycles + FILTER_CYCLES + 1.
- The byte is written on the clock edge after the STOP strobe. not_empty reads 1 from the next cycle.
- A read returns the current head combinationally. The pop takes effect at that edge, so a read held for N cycles pops N entries.
- FIFO pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

## Test plan
- Frame 0x1C (parity 0, stop 1):
  - status then reads 0x0000_0101.
  - data read returns 0x0000_011C.
  - status then reads 0x0000_0000.
- Frame 0x1C with parity 1 -> no push; status 0x0000_0008. Write 0x8 to status -> status reads 0x0000_0000.
- 17 valid frames 0x01..0x11 with no reads:
  - status reads 0x0000_1007.
  - 16 data reads return 0x101..0x110 in order.
  - the 17th read returns 0.
- Start bit + 3 data bits, then clock held high for TIMEOUT_CYCLES -> status 0x0000_0008, FSM in IDLE. A following valid frame 0xF0 is received as 0x1F0.
- FIFO holds 1 byte. Data read on the same edge as a push of 0x5A -> count stays 1, next data read returns 0x15A. Repeat at full: count stays 16, overflow stays 0.
- Edge cases:
  - reset asserted after 4 data bits -> status 0 and no partial byte.
  - read at BASE_ADDRESS+8 -> bus_data_fetched 0.
  - write to data register -> no state change.

Source files
------------

// File: rtl/ps2_keyboard_interface.sv
// PS/2 device-to-host receiver with a byte FIFO, exposed on the core data bus
// as a status register (+0) and a data register (+4).
//
// state  | meaning
// IDLE   | waiting for a start bit (strobe with data=0)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then push or flag an error
module ps2_keyboard_interface #(
  parameter logic [31:0] BASE_ADDRESS   = 32'hFF20_0100,
  parameter int          FIFO_DEPTH     = 16,
  parameter int          FILTER_CYCLES  = 8,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clock,
  input  logic        ps2_data,
  input  logic [31:0] bus_address,
  input  logic [31:0] bus_write_data,
  input  logic [2:0]  bus_format,
  input  logic        bus_read_enable,
  input  logic        bus_write_enable,
  output logic [31:0] bus_data_fetched
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // index 0 carries ps2_clock, index 1 carries ps2_data
  logic [1:0]    sync0, sync1, filt;
  logic [FW-1:0] fcnt [2];
  logic          filt_clk_d;
  logic          strobe, sample;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] timer;
  logic          push_req, ferr_set;
  logic [7:0]    push_byte;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          overflow, frame_error;
  logic          not_empty, full, push_ok, pop;
  logic          selected, status_wr;
  logic [31:0]   status_word, data_word;
  logic          unused;

  assign unused = ^{bus_format, bus_write_data[31:4], bus_write_data[1:0], bus_address[1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      sync0      <= 2'b11;
      sync1      <= 2'b11;
      filt       <= 2'b11;
      fcnt[0]    <= '0;
      fcnt[1]    <= '0;
      filt_clk_d <= 1'b1;
    end else begin
      sync0      <= {ps2_data, ps2_clock};
      sync1      <= sync0;
      filt_clk_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync1[i] != filt[i]) begin
          if (fcnt[i] == FW'(FILTER_CYCLES - 1)) begin
            filt[i] <= sync1[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + FW'(1);
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  assign strobe = filt_clk_d & ~filt[0];
  assign sample = filt[1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      timer     <= '0;
      push_req  <= 1'b0;
      push_byte <= '0;
      ferr_set  <= 1'b0;
    end else begin
      push_req <= 1'b0;
      ferr_set <= 1'b0;
      if (state == IDLE || strobe) timer <= '0;
      else                         timer <= timer + TW'(1);

      if (state != IDLE && !strobe && timer == TW'(TIMEOUT_CYCLES - 1)) begin
        state    <= IDLE;
        shift    <= '0;
        ferr_set <= 1'b1;
      end else if (strobe) begin
        case (state)
          IDLE: begin
            if (!sample) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift   <= {sample, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= sample;
            state <= STOP;
          end
          STOP: begin
            if (sample && (^{shift, par})) begin
              push_req  <= 1'b1;
              push_byte <= shift;
            end else begin
              ferr_set <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign selected  = bus_address[31:3] == BASE_ADDRESS[31:3];
  assign not_empty = count != 5'd0;
  assign full      = count == 5'(FIFO_DEPTH);
  assign pop       = selected & bus_read_enable & bus_address[2] & not_empty;
  assign push_ok   = push_req & (~full | pop);
  assign status_wr = selected & bus_write_enable & ~bus_address[2];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_byte;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      // a set event in the same cycle as a clear wins
      overflow    <= (overflow & ~(status_wr & bus_write_data[2])) | (push_req & ~push_ok);
      frame_error <= (frame_error & ~(status_wr & bus_write_data[3])) | ferr_set;
    end
  end

  assign status_word = {19'd0, count, 4'd0, frame_error, overflow, full, not_empty};
  assign data_word   = not_empty ? {23'd0, 1'b1, mem[rd_ptr]} : 32'd0;

  always_comb begin
    bus_data_fetched = 32'd0;
    if (selected && bus_read_enable)
      bus_data_fetched = bus_address[2] ? data_word : status_word;
  end

endmodule

// File: tb/tb_ps2_keyboard_interface.sv
// Bench for ps2_keyboard_interface: drives PS/2 frames bit by bit and checks
// the bus registers against a queue-based model of the keyboard buffer.
module tb_ps2_keyboard_interface;

  localparam logic [31:0] BASE  = 32'hFF20_0100;
  localparam int          DEPTH = 16;
  localparam int          FILT  = 4;
  localparam int          TMO   = 400;
  localparam int          H     = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clock = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] bus_address = 32'd0;
  logic [31:0] bus_write_data = 32'd0;
  logic [2:0]  bus_format = 3'd2;
  logic        bus_read_enable = 1'b0;
  logic        bus_write_enable = 1'b0;
  logic [31:0] bus_data_fetched;

  ps2_keyboard_interface #(
    .BASE_ADDRESS(BASE), .FIFO_DEPTH(DEPTH), .FILTER_CYCLES(FILT), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset(reset), .ps2_clock(ps2_clock), .ps2_data(ps2_data),
    .bus_address(bus_address), .bus_write_data(bus_write_data), .bus_format(bus_format),
    .bus_read_enable(bus_read_enable), .bus_write_enable(bus_write_enable),
    .bus_data_fetched(bus_data_fetched)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0] q[$];
  bit m_ovf = 1'b0;
  bit m_ferr = 1'b0;

  function automatic logic [31:0] m_status();
    return {19'd0, 5'(q.size()), 4'd0, m_ferr, m_ovf, q.size() == DEPTH, q.size() != 0};
  endfunction

  function automatic logic [31:0] m_data();
    return (q.size() == 0) ? 32'd0 : {23'd0, 1'b1, q[0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    q.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] addr, output logic [31:0] d);
    @(negedge clock); bus_address = addr; bus_read_enable = 1'b1;
    #2 d = bus_data_fetched;
    @(negedge clock); bus_read_enable = 1'b0;
  endtask

  task automatic write_reg(input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clock); bus_address = addr; bus_write_data = wd; bus_write_enable = 1'b1;
    @(negedge clock); bus_write_enable = 1'b0;
  endtask

  task automatic chk_status(input string tag);
    logic [31:0] d;
    read_reg(BASE, d);
    check(tag, d, m_status());
  endtask

  task automatic chk_pop(input string tag);
    logic [31:0] d;
    read_reg(BASE + 32'd4, d);
    check(tag, d, m_data());
    if (q.size() != 0) void'(q.pop_front());
  endtask

  // Sends the first n bits of a frame; optionally reads the data register on
  // the very edge where the stop bit's byte lands in the FIFO.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit rd_at_push);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      @(negedge clock); ps2_data = bits[i];
      repeat (H - 1) @(negedge clock);
      ps2_clock = 1'b0;
      if (i == 10 && rd_at_push) begin
        repeat (FILT + 3) @(negedge clock);
        bus_address = BASE + 32'd4; bus_read_enable = 1'b1;
        #2 d = bus_data_fetched;
        check("push_pop_head", d, m_data());
        @(negedge clock); bus_read_enable = 1'b0;
        repeat (H - FILT - 4) @(negedge clock);
      end else begin
        repeat (H) @(negedge clock);
      end
      ps2_clock = 1'b1;
    end
    @(negedge clock); ps2_data = 1'b1;
    repeat (H) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit rd_at_push);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    send_bits(bits, 11, rd_at_push);
    if (bad_par || bad_stop) m_ferr = 1'b1;
    else if (rd_at_push && q.size() != 0) begin
      void'(q.pop_front());
      q.push_back(b);
    end else if (q.size() < DEPTH) q.push_back(b);
    else m_ovf = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    int          kind;

    do_reset();
    #2 check("reset_fetched", bus_data_fetched, 32'd0);
    chk_status("reset_status");

    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    read_reg(BASE, d);
    check("frame_1c_status", d, 32'h0000_0101);
    chk_pop("frame_1c_data");
    chk_status("frame_1c_status_after");

    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    chk_status("bad_parity_status");
    write_reg(BASE, 32'h8); m_ferr = 1'b0;
    chk_status("ferr_cleared");

    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0);
    read_reg(BASE, d);
    check("overflow_status", d, 32'h0000_1007);
    for (int i = 0; i < 17; i++) chk_pop("overflow_drain");
    write_reg(BASE, 32'h4); m_ovf = 1'b0;
    chk_status("ovf_cleared");

    send_bits(11'b000_0000_1010, 4, 1'b0);
    repeat (TMO + 50) @(negedge clock);
    m_ferr = 1'b1;
    chk_status("timeout_status");
    write_reg(BASE, 32'h8); m_ferr = 1'b0;
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    chk_pop("after_timeout_f0");

    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
    chk_status("push_pop_count1");
    chk_pop("push_pop_5a");
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    chk_status("push_pop_full");
    write_reg(BASE + 32'd4, 32'hFFFF_FFFF);
    chk_status("data_write_ignored");
    read_reg(BASE + 32'd8, d);
    check("unselected_read", d, 32'd0);
    @(negedge clock); bus_address = BASE + 32'd4; bus_read_enable = 1'b0;
    #2 check("no_read_enable", bus_data_fetched, 32'd0);
    while (q.size() != 0) chk_pop("full_drain");
    chk_pop("empty_read");

    send_bits(11'b000_0110_1010, 5, 1'b0);
    do_reset();
    chk_status("reset_midframe_status");
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    chk_pop("reset_midframe_next");

    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      kind = int'($urandom_range(0, 7));
      send_frame(b, kind == 0, kind == 1, 1'b0);
      if ($urandom_range(0, 2) == 0) chk_pop("rand_pop");
      if (i % 6 == 5) chk_status("rand_status");
    end
    chk_status("rand_final_status");
    while (q.size() != 0) chk_pop("rand_drain");
    write_reg(BASE, 32'hC); m_ovf = 1'b0; m_ferr = 1'b0;
    chk_status("rand_cleared");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
